// File: rtl/rv_mc_pkg.sv
// rv_mc_pkg: shared definitions for the multicycle RV32I controller.
//   state_e     : FSM states (4-bit, exported on state_o)
//   OP_*        : RV32I major opcodes understood by the controller
//   *_e         : datapath mux / ALU encodings driven by the controller
//   op_class()  : opcode -> ALU decoding class
//   imm_sel()   : opcode -> immediate format
package rv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_XOR = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_IMM       = 2'b11
  } result_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_e;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'b00,
    CLS_R     = 2'b01,
    CLS_I     = 2'b10,
    CLS_B     = 2'b11
  } op_class_e;

  function automatic op_class_e op_class(input logic [6:0] op);
    case (op)
      OP_RTYPE:  return CLS_R;
      OP_ITYPE:  return CLS_I;
      OP_BRANCH: return CLS_B;
      default:   return CLS_OTHER;
    endcase
  endfunction

  function automatic imm_e imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv_mc_controller_alu_decoder.sv
// rv_alu_decoder: combinational ALU operation decode.
//   op_class      in  2  op_class_e of the current instruction
//   func3         in  3  IR[14:12]
//   func7b5       in  1  IR[30]
//   alu_ctrl      out 3  ALU operation for EXECR/EXECI/BRANCH
//   func3_illegal out 1  func3 not supported for this class
module rv_alu_decoder
  import rv_mc_pkg::*;
(
  input  logic [1:0] op_class,
  input  logic [2:0] func3,
  input  logic       func7b5,
  output logic [2:0] alu_ctrl,
  output logic       func3_illegal
);

  op_class_e cls;
  assign cls = op_class_e'(op_class);

  always_comb begin
    alu_ctrl      = ALU_ADD;
    func3_illegal = 1'b0;
    case (cls)
      CLS_R, CLS_I: begin
        case (func3)
          // Only register-register ops have a SUB form; ADDI ignores IR[30].
          3'b000:  alu_ctrl = (cls == CLS_R && func7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b100:  alu_ctrl = ALU_XOR;
          default: func3_illegal = 1'b1;
        endcase
      end
      CLS_B: begin
        alu_ctrl = ALU_SUB;
        case (func3)
          3'b000, 3'b001, 3'b100, 3'b101: func3_illegal = 1'b0;
          default:                        func3_illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_mc_controller.sv
// rv_mc_controller: multicycle RV32I control FSM with memory handshake.
//   clk, rst (sync, active-low)
//   opcode/func3/func7  instruction fields from IR
//   zero/sign           ALU flags for branch resolution
//   mem_ready           memory completes current access
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  datapath strobes
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc  datapath selects
//   mem_req, illegal, state_o  memory request, trap flag, debug state
module rv_mc_controller
  import rv_mc_pkg::*;
#(
  parameter logic MEM_HANDSHAKE = 1'b1,
  parameter logic TRAP_EN       = 1'b1
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       sign,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       mem_req,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_e     state_q, state_d;
  logic       ready;
  logic       known_op;
  logic       decode_illegal;
  logic       taken;
  logic [2:0] dec_alu;
  logic       dec_f3_illegal;
  op_class_e  cls;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, req, trap;
  logic [5:0] unused_func7;

  assign unused_func7 = {func7[6], func7[4:0]};
  assign ready        = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign cls          = op_class(opcode);
  assign ImmSrc       = imm_sel(opcode);
  assign state_o      = state_q;

  rv_alu_decoder u_alu_dec (
    .op_class      (cls),
    .func3         (func3),
    .func7b5       (func7[5]),
    .alu_ctrl      (dec_alu),
    .func3_illegal (dec_f3_illegal)
  );

  always_comb begin
    known_op = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: known_op = 1'b1;
      default: known_op = 1'b0;
    endcase
  end

  assign decode_illegal = !known_op || dec_f3_illegal;

  always_comb begin
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = sign;
      3'b101:  taken = !sign;
      default: taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (decode_illegal) begin
          state_d = TRAP_EN ? S_TRAP : S_FETCH;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXECR;
            OP_ITYPE:          state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            default:           state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        if (opcode == OP_LOAD)       state_d = S_MEMREAD;
        else if (opcode == OP_STORE) state_d = S_MEMWRITE;
        else                         state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs; strobes are gated by reset below
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    req        = 1'b0;
    trap       = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        req       = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = ready;
        pc_write  = ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        req     = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        req       = 1'b1;
        adr_src   = 1'b1;
        mem_write = ready;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        ALUControl = dec_alu;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec_alu;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_SUB;
        pc_write   = taken;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        pc_write = 1'b1;
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
      end
      S_LUI: begin
        ResultSrc = RES_IMM;
        reg_write = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks side effects in the same cycle so an in-flight write never lands.
  assign PCWrite  = rst & pc_write;
  assign AdrSrc   = rst & adr_src;
  assign MemWrite = rst & mem_write;
  assign IRWrite  = rst & ir_write;
  assign RegWrite = rst & reg_write;
  assign mem_req  = rst & req;
  assign illegal  = rst & trap;

endmodule

// File: doc/rv_mc_controller.md
Name: rv_mc_controller

Overview:
- Next-generation multicycle RV32I control unit. Drives the existing datapath strobe set and adds a memory ready handshake with configurable wait states.
- Adds branch variants (BNE/BLT/BGE), JALR, LUI and an illegal-instruction trap.
- Sits beside the datapath in the processor top and replaces the previous controller one-for-one.
- Adds ports mem_req, mem_ready, illegal and state_o.

Parameters:
- MEM_HANDSHAKE, 1, 1: FETCH/MEMREAD/MEMWRITE wait for mem_ready. 0: mem_ready ignored and treated as 1.
- TRAP_EN, 1, 1: an illegal instruction enters TRAP. 0: an illegal instruction is a NOP and the FSM returns to FETCH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- opcode  in  7  IR[6:0]
- func3  in  3  IR[14:12]
- func7  in  7  IR[31:25]
- zero  in  1  ALU result == 0
- sign  in  1  ALU result sign bit
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath strobes
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 Imm
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 Imm, 10 const 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- mem_req  out  1  memory access requested
- illegal  out  1  trap flag
- state_o  out  4  current state, for debug

Behaviour:
- FSM is Moore with registered state. ImmSrc is combinational from opcode in every state.
- rst=0 at a clock edge: state <= FETCH. While rst=0, all strobes, mem_req and illegal are forced to 0 combinationally. Unlisted outputs default to 0.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - If mem_ready: IRWrite=1, PCWrite=1, next state DECODE.
  - Otherwise: IRWrite=0, PCWrite=0, remain in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut <= OldPC+imm). Branch on opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - Anything else, or an unsupported func3 -> TRAP (TRAP_EN=1) or FETCH (TRAP_EN=0).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next MEMREAD if opcode is load, MEMWRITE if store.
- MEMREAD: mem_req=1, AdrSrc=1. mem_ready -> MEMWB, else hold.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 on the mem_ready cycle only. Then FETCH; hold while not ready.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- EXECR / EXECI: ALUSrcA=10, ALUSrcB=00 (R) or 01 (I). Then ALUWB.
  - ALUControl from func3: 000 add (sub only if R-type and func7[5]=1), 111 and, 110 or, 010 slt, 100 xor. Other func3 values are illegal.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=taken. Then FETCH.
  - taken: func3 000 = zero, 001 = !zero, 100 = sign, 101 = !sign. Other func3 values are illegal at DECODE.
- JALR: ALUSrcA=10, ALUSrcB=01, add (ALUOut <= rs1+imm), then JAL.
- JAL: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, add (ALUOut <= OldPC+4), then ALUWB.
- LUI: ResultSrc=11, RegWrite=1, then FETCH.
- TRAP: illegal=1, all strobes 0. Absorbing until rst=0.
- mem_ready outside a mem_req state is ignored.
- Reset mid-access drops mem_req on the same cycle, with no partial write.
- Cycle counts with zero wait: R/I/LUI-class 4 cycles (LUI 3), load 5, store 4, branch 3, JAL 4, JALR 5. Each wait cycle adds 1.

Decomposition:
- Package rv_mc_pkg holds:
  - state enum (4-bit)
  - opcode constants
  - ALUControl, ALUSrcA/B, ResultSrc and ImmSrc encodings
- Sub-module rv_alu_decoder: combinational {opcode class, func3, func7[5]} -> ALUControl + func3_illegal.

Test Plan:
- add x3,x1,x2 (func7=0000000), MEM_HANDSHAKE=1, mem_ready high -> states FETCH,DECODE,EXECR,ALUWB. RegWrite=1 only in ALUWB. ALUControl=000.
- lw with mem_ready low for 2 cycles in both FETCH and MEMREAD -> IRWrite pulses once after the waits. Total 9 cycles. RegWrite with ResultSrc=01 in MEMWB.
- bne with zero=0 -> PCWrite=1 in BRANCH. Same instruction with zero=1 -> PCWrite=0. blt with sign=1 -> PCWrite=1.
- jalr -> JALR, JAL, ALUWB sequence. PCWrite=1 in JAL, RegWrite=1 in ALUWB, state_o path matches.
- opcode 1111111, TRAP_EN=1 -> TRAP, illegal=1 held for 10 cycles. rst=0 for one edge -> FETCH, illegal=0, mem_req=1. With TRAP_EN=0 -> back to FETCH, no strobes.
- rst=0 asserted during MEMWRITE while waiting -> MemWrite never 1, mem_req=0 during reset, FETCH after reset.
